// File: rtl/cas_key_pkg.sv
// Shared sizing, counter width and FSM state type for the CAS-Lock key loader.
package cas_key_pkg;

    localparam int KEY_W_DEF   = 64;
    localparam int CHUNK_W_DEF = 8;

    function automatic int num_chunks(input int key_w, input int chunk_w);
        return key_w / chunk_w;
    endfunction

    localparam int NUM_CHUNKS_DEF = num_chunks(KEY_W_DEF, CHUNK_W_DEF);
    localparam int CNT_W          = $clog2(NUM_CHUNKS_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2,
        ERR  = 2'd3
    } state_e;

endpackage

// File: rtl/cas_key_shadow.sv
// Shadow key register: one chunk written per cycle at a chunk index, with a
// synchronous zero that takes priority over the write.
module cas_key_shadow
    import cas_key_pkg::*;
#(
    parameter int KEY_W      = KEY_W_DEF,
    parameter int CHUNK_W    = CHUNK_W_DEF,
    parameter int NUM_CHUNKS = num_chunks(KEY_W, CHUNK_W),
    parameter int IDX_W      = $clog2(NUM_CHUNKS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [CHUNK_W-1:0] wr_data,
    input  logic               zero,
    output logic [KEY_W-1:0]   shadow
);

    logic [KEY_W-1:0] shadow_q;
    logic [KEY_W-1:0] shadow_d;

    // Next shadow value: zeroing wins over a chunk write
    always_comb begin
        shadow_d = shadow_q;
        if (zero) begin
            shadow_d = '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_CHUNKS; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    shadow_d[i*CHUNK_W +: CHUNK_W] = wr_data;
                end else begin
                    shadow_d[i*CHUNK_W +: CHUNK_W] = shadow_q[i*CHUNK_W +: CHUNK_W];
                end
            end
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Shadow storage
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign shadow = shadow_q;

endmodule

// File: rtl/cas_key_loader.sv
// Byte-stream key loader with shadow/active double buffering for a CAS-Lock netlist.
// Optional macro CAS_KEY_LOCKOUT_EN: one-shot key, locks after the first commit until rst.
module cas_key_loader
    import cas_key_pkg::*;
#(
    parameter int KEY_W   = KEY_W_DEF,
    parameter int CHUNK_W = CHUNK_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_in_valid,
    output logic               key_in_ready,
    input  logic [CHUNK_W-1:0] key_in_data,
    input  logic               key_in_last,
    input  logic               commit,
    input  logic               clear,
    output logic [KEY_W-1:0]   key_out,
    output logic               key_valid,
    output logic               load_err
`ifdef CAS_KEY_LOCKOUT_EN
    ,
    output logic               key_locked
`endif
);

    localparam int NUM_CHUNKS = num_chunks(KEY_W, CHUNK_W);
    localparam int CW         = $clog2(NUM_CHUNKS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CHUNKS - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [KEY_W-1:0] key_out_q, key_out_d;
    logic             key_valid_q, key_valid_d;
    logic             load_err_q, load_err_d;
    logic             locked_s;
    logic             xfer_s;
    logic             wr_en_s;
    logic             zero_s;
    logic [KEY_W-1:0] shadow_s;

`ifdef CAS_KEY_LOCKOUT_EN
    logic locked_q, locked_d;
    assign locked_s   = locked_q;
    assign key_locked = locked_q;
`else
    assign locked_s = 1'b0;
`endif

    // Ready is a pure decode of registered state, held low during reset
    assign key_in_ready = ~rst & ~locked_s & ((state_q == IDLE) | (state_q == LOAD));
    assign xfer_s       = key_in_valid & key_in_ready;

    cas_key_shadow #(
        .KEY_W      (KEY_W),
        .CHUNK_W    (CHUNK_W),
        .NUM_CHUNKS (NUM_CHUNKS),
        .IDX_W      (CW)
    ) u_shadow (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_s),
        .wr_idx  (cnt_q),
        .wr_data (key_in_data),
        .zero    (zero_s),
        .shadow  (shadow_s)
    );

    // Next-state, counter, shadow control and active-key update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_out_d   = key_out_q;
        key_valid_d = key_valid_q;
        load_err_d  = load_err_q;
        wr_en_s     = 1'b0;
        zero_s      = 1'b0;
`ifdef CAS_KEY_LOCKOUT_EN
        locked_d    = locked_q;
`endif
        if (clear && !locked_s) begin
            state_d    = IDLE;
            cnt_d      = '0;
            zero_s     = 1'b1;
            load_err_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (xfer_s) begin
                        wr_en_s = 1'b1;
                        if ((cnt_q == LAST_IDX) && key_in_last) begin
                            state_d = FULL;
                            cnt_d   = '0;
                        end else if ((cnt_q == LAST_IDX) || key_in_last) begin
                            // Framing error: discard everything collected so far
                            state_d    = ERR;
                            cnt_d      = '0;
                            zero_s     = 1'b1;
                            load_err_d = 1'b1;
                        end else begin
                            state_d = LOAD;
                            cnt_d   = cnt_q + CW'(1);
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                FULL: begin
                    if (commit && !locked_s) begin
                        key_out_d   = shadow_s;
                        key_valid_d = 1'b1;
                        state_d     = IDLE;
                        zero_s      = 1'b1;
`ifdef CAS_KEY_LOCKOUT_EN
                        locked_d    = 1'b1;
`endif
                    end else begin
                        state_d = FULL;
                    end
                end
                ERR: begin
                    state_d = ERR;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    zero_s  = 1'b1;
                end
            endcase
        end
    end

    // Control and active-key registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_out_q   <= '0;
            key_valid_q <= 1'b0;
            load_err_q  <= 1'b0;
`ifdef CAS_KEY_LOCKOUT_EN
            locked_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_out_q   <= key_out_d;
            key_valid_q <= key_valid_d;
            load_err_q  <= load_err_d;
`ifdef CAS_KEY_LOCKOUT_EN
            locked_q    <= locked_d;
`endif
        end
    end

    assign key_out   = key_out_q;
    assign key_valid = key_valid_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_cas_key_loader.sv
// Self-checking bench for cas_key_loader: directed scenarios plus randomized
// traffic checked against a queue-based model of the key-loading rules.
module tb_cas_key_loader;

    localparam int NC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_in_valid = 1'b0;
    logic        key_in_ready;
    logic [7:0]  key_in_data = 8'h00;
    logic        key_in_last = 1'b0;
    logic        commit = 1'b0;
    logic        clear = 1'b0;
    logic [63:0] key_out;
    logic        key_valid;
    logic        load_err;
`ifdef CAS_KEY_LOCKOUT_EN
    logic        key_locked;
`endif

    int errors = 0;
    int checks = 0;

    // Model: received chunks, completion/error flags, active key
    logic [7:0]  mq[$];
    bit          m_full, m_err, m_lerr, m_kv, m_locked;
    logic [63:0] m_key;

    cas_key_loader dut (
        .clk          (clk),
        .rst          (rst),
        .key_in_valid (key_in_valid),
        .key_in_ready (key_in_ready),
        .key_in_data  (key_in_data),
        .key_in_last  (key_in_last),
        .commit       (commit),
        .clear        (clear),
        .key_out      (key_out),
        .key_valid    (key_valid),
        .load_err     (load_err)
`ifdef CAS_KEY_LOCKOUT_EN
        ,
        .key_locked   (key_locked)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit m_ready();
        return !rst && !m_full && !m_err && !m_locked;
    endfunction

    // Drive one cycle of inputs, advance the model by the loader's rules, sample #1 after the edge
    task automatic tick(input bit v, input logic [7:0] d, input bit l, input bit c, input bit clr);
        key_in_valid = v;
        key_in_data  = d;
        key_in_last  = l;
        commit       = c;
        clear        = clr;
        if (rst) begin
            mq.delete();
            m_full = 0; m_err = 0; m_lerr = 0; m_kv = 0; m_locked = 0; m_key = 64'd0;
        end else if (clr && !m_locked) begin
            mq.delete();
            m_full = 0; m_err = 0; m_lerr = 0;
        end else if (m_full) begin
            if (c && !m_locked) begin
                for (int i = 0; i < NC; i++) m_key[i*8 +: 8] = mq[i];
                m_kv = 1;
                mq.delete();
                m_full = 0;
`ifdef CAS_KEY_LOCKOUT_EN
                m_locked = 1;
`endif
            end
        end else if (v && m_ready()) begin
            mq.push_back(d);
            if (l && mq.size() == NC) begin
                m_full = 1;
            end else if (l || mq.size() == NC) begin
                mq.delete();
                m_err = 1;
                m_lerr = 1;
            end
        end
        @(posedge clk);
        #1;
        key_in_valid = 0; key_in_last = 0; commit = 0; clear = 0;
    endtask

    task automatic idle();
        tick(0, 8'h00, 0, 0, 0);
    endtask

    task automatic send_key(input logic [63:0] k, input bit last_at_end, input bit commit_with_last);
        for (int i = 0; i < NC; i++)
            tick(1, k[i*8 +: 8], last_at_end && (i == NC-1), commit_with_last && (i == NC-1), 0);
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        checks++; if (key_in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_hi: got %b exp 0", key_in_ready); end
        checks++; if (key_out !== 64'd0) begin errors++; $display("FAIL rst_key_out: got %h exp 0", key_out); end
        checks++; if (key_valid !== 1'b0 || load_err !== 1'b0) begin errors++; $display("FAIL rst_flags: got kv=%b le=%b exp 0 0", key_valid, load_err); end
        rst = 0;
        #1;
        checks++; if (key_in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b exp 1", key_in_ready); end
`ifdef CAS_KEY_LOCKOUT_EN
        checks++; if (key_locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %b exp 0", key_locked); end
`endif
    endtask

    task automatic test_load_commit();
        send_key(64'h0123_4567_89AB_CDEF, 1, 0);
        checks++; if (key_in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b exp 0", key_in_ready); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL full_kv_early: got %b exp 0", key_valid); end
        tick(0, 8'h00, 0, 1, 0);
        checks++; if (key_out !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL commit_key: got %h exp %h", key_out, 64'h0123456789ABCDEF); end
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL commit_kv: got %b exp 1", key_valid); end
    endtask

    task automatic test_short_last();
        logic [63:0] prev;
        prev = key_out;
        tick(1, 8'h11, 0, 0, 0);
        tick(1, 8'h22, 0, 0, 0);
        tick(1, 8'h33, 1, 0, 0);
        checks++; if (load_err !== 1'b1 || key_in_ready !== 1'b0) begin errors++; $display("FAIL short_err: got le=%b rdy=%b exp 1 0", load_err, key_in_ready); end
        checks++; if (key_out !== prev) begin errors++; $display("FAIL short_key_hold: got %h exp %h", key_out, prev); end
        tick(0, 8'h00, 0, 0, 1);
        checks++; if (load_err !== 1'b0 || key_in_ready !== 1'b1) begin errors++; $display("FAIL short_clear: got le=%b rdy=%b exp 0 1", load_err, key_in_ready); end
    endtask

    task automatic test_no_last();
        logic [63:0] prev;
        bit          prev_kv;
        prev = key_out;
        prev_kv = key_valid;
        send_key({$urandom, $urandom}, 0, 0);
        checks++; if (load_err !== 1'b1 || key_in_ready !== 1'b0) begin errors++; $display("FAIL nolast_err: got le=%b rdy=%b exp 1 0", load_err, key_in_ready); end
        tick(0, 8'h00, 0, 1, 0);
        checks++; if (key_out !== prev || key_valid !== prev_kv) begin errors++; $display("FAIL err_commit: got %h/%b exp %h/%b", key_out, key_valid, prev, prev_kv); end
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b exp 1", load_err); end
        tick(0, 8'h00, 0, 0, 1);
    endtask

    task automatic test_double_buffer();
        logic [63:0] ka, kb, kc;
        ka = {$urandom, $urandom};
        kb = {$urandom, $urandom};
        kc = {$urandom, $urandom};
        send_key(ka, 1, 0);
        tick(0, 8'h00, 0, 1, 0);
        checks++; if (key_out !== ka) begin errors++; $display("FAIL db_key_a: got %h exp %h", key_out, ka); end
        send_key(kb, 1, 1);
        idle();
        checks++; if (key_out !== ka) begin errors++; $display("FAIL db_hold_a: got %h exp %h", key_out, ka); end
        tick(0, 8'h00, 0, 1, 0);
        checks++; if (key_out !== kb) begin errors++; $display("FAIL db_key_b: got %h exp %h", key_out, kb); end
        send_key(kc, 1, 0);
        tick(0, 8'h00, 0, 1, 1);
        checks++; if (key_out !== kb || key_in_ready !== 1'b1) begin errors++; $display("FAIL db_clear_commit: got %h rdy=%b exp %h 1", key_out, key_in_ready, kb); end
    endtask

    task automatic test_mid_reset();
        logic [63:0] k;
        for (int i = 0; i < 4; i++) tick(1, 8'($urandom), 0, 0, 0);
        rst = 1;
        idle();
        rst = 0;
        #1;
        checks++; if (key_out !== 64'd0 || key_valid !== 1'b0 || load_err !== 1'b0) begin errors++; $display("FAIL midrst_state: got %h kv=%b le=%b exp 0", key_out, key_valid, load_err); end
        k = {$urandom, $urandom};
        send_key(k, 1, 0);
        tick(0, 8'h00, 0, 1, 0);
        checks++; if (key_out !== k || key_valid !== 1'b1) begin errors++; $display("FAIL midrst_reload: got %h kv=%b exp %h 1", key_out, key_valid, k); end
    endtask

    task automatic test_random();
        bit v, l, c, clr;
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            l   = (mq.size() == NC-1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0);
            c   = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 40) == 0);
            tick(v, 8'($urandom), l, c, clr);
            checks++; if (key_in_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready[%0d]: got %b exp %b", n, key_in_ready, m_ready()); end
            checks++; if (key_out !== m_key) begin errors++; $display("FAIL rnd_key[%0d]: got %h exp %h", n, key_out, m_key); end
            checks++; if (key_valid !== m_kv || load_err !== m_lerr) begin errors++; $display("FAIL rnd_flags[%0d]: got kv=%b le=%b exp %b %b", n, key_valid, load_err, m_kv, m_lerr); end
        end
    endtask

`ifdef CAS_KEY_LOCKOUT_EN
    task automatic test_lockout();
        logic [63:0] k;
        k = {$urandom, $urandom};
        send_key(k, 1, 0);
        tick(0, 8'h00, 0, 1, 0);
        checks++; if (key_locked !== 1'b1 || key_in_ready !== 1'b0) begin errors++; $display("FAIL lock_set: got lk=%b rdy=%b exp 1 0", key_locked, key_in_ready); end
        tick(1, 8'h5A, 1, 0, 0);
        tick(0, 8'h00, 0, 0, 1);
        tick(0, 8'h00, 0, 1, 0);
        checks++; if (key_out !== k || key_in_ready !== 1'b0 || key_locked !== 1'b1) begin errors++; $display("FAIL lock_hold: got %h rdy=%b lk=%b exp %h 0 1", key_out, key_in_ready, key_locked, k); end
        do_reset();
        checks++; if (key_in_ready !== 1'b1 || key_locked !== 1'b0) begin errors++; $display("FAIL lock_rst: got rdy=%b lk=%b exp 1 0", key_in_ready, key_locked); end
    endtask
`endif

    initial begin
        m_full = 0; m_err = 0; m_lerr = 0; m_kv = 0; m_locked = 0; m_key = 64'd0;
        test_reset();
        test_load_commit();
        do_reset();
        test_short_last();
        test_no_last();
`ifndef CAS_KEY_LOCKOUT_EN
        test_double_buffer();
`endif
        test_mid_reset();
        do_reset();
        test_random();
`ifdef CAS_KEY_LOCKOUT_EN
        do_reset();
        test_lockout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
